// File: rtl/biriscv_inst_encoder.sv
// RV32I/M instruction encoder feeding a small output FIFO with push/pop handshakes.
// Define BIRISCV_ENCODER_MULDIV_EN to enable encoding of op 15 (MUL); otherwise it is rejected.
module biriscv_inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_accept_o,
    input  logic [3:0]               req_op_i,
    input  logic [4:0]               req_rd_i,
    input  logic [4:0]               req_rs1_i,
    input  logic [4:0]               req_rs2_i,
    input  logic [31:0]              req_imm_i,
    output logic                     inst_valid_o,
    input  logic                     inst_accept_i,
    output logic [31:0]              inst_opcode_o,
    output logic                     inst_error_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic                     flush_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_MUL
    } op_e;

    // Every non-U/J format shares the R-type field boundaries, so one packer covers them all.
    function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] f_rs2,
                                           input logic [4:0] f_rs1, input logic [2:0] f3,
                                           input logic [4:0] f_rd, input logic [6:0] opc);
        return {f7, f_rs2, f_rs1, f3, f_rd, opc};
    endfunction

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic error_q, error_d;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        imm12_ok, shamt_ok, lui_ok, br_ok, jal_ok;
    logic        push, pop;

    assign imm12_ok = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
    assign shamt_ok = (req_imm_i[31:5] == '0);
    assign lui_ok   = (req_imm_i[11:0] == '0);
    assign br_ok    = !req_imm_i[0] && ((req_imm_i[31:12] == '0) || (req_imm_i[31:12] == '1));
    assign jal_ok   = !req_imm_i[0] && ((req_imm_i[31:20] == '0) || (req_imm_i[31:20] == '1));

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        case (req_op_i)
            OP_ADDI: begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b000, req_rd_i, OPC_OPIMM); enc_bad = !imm12_ok; end
            OP_SLTI: begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b010, req_rd_i, OPC_OPIMM); enc_bad = !imm12_ok; end
            OP_XORI: begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b100, req_rd_i, OPC_OPIMM); enc_bad = !imm12_ok; end
            OP_ORI:  begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b110, req_rd_i, OPC_OPIMM); enc_bad = !imm12_ok; end
            OP_ANDI: begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b111, req_rd_i, OPC_OPIMM); enc_bad = !imm12_ok; end
            OP_SLLI: begin enc_word = pack_r(7'b0000000, req_imm_i[4:0], req_rs1_i, 3'b001, req_rd_i, OPC_OPIMM); enc_bad = !shamt_ok; end
            OP_SRLI: begin enc_word = pack_r(7'b0000000, req_imm_i[4:0], req_rs1_i, 3'b101, req_rd_i, OPC_OPIMM); enc_bad = !shamt_ok; end
            OP_SRAI: begin enc_word = pack_r(7'b0100000, req_imm_i[4:0], req_rs1_i, 3'b101, req_rd_i, OPC_OPIMM); enc_bad = !shamt_ok; end
            OP_ADD:  enc_word = pack_r(7'b0000000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, OPC_OP);
            OP_SUB:  enc_word = pack_r(7'b0100000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, OPC_OP);
            OP_LUI:  begin enc_word = {req_imm_i[31:12], req_rd_i, OPC_LUI}; enc_bad = !lui_ok; end
            OP_LW:   begin enc_word = pack_r(req_imm_i[11:5], req_imm_i[4:0], req_rs1_i, 3'b010, req_rd_i, OPC_LOAD); enc_bad = !imm12_ok; end
            OP_SW:   begin enc_word = pack_r(req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010, req_imm_i[4:0], OPC_STORE); enc_bad = !imm12_ok; end
            OP_BEQ:  begin
                enc_word = pack_r({req_imm_i[12], req_imm_i[10:5]}, req_rs2_i, req_rs1_i, 3'b000,
                                  {req_imm_i[4:1], req_imm_i[11]}, OPC_BRANCH);
                enc_bad  = !br_ok;
            end
            OP_JAL:  begin
                enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12], req_rd_i, OPC_JAL};
                enc_bad  = !jal_ok;
            end
`ifdef BIRISCV_ENCODER_MULDIV_EN
            OP_MUL:  enc_word = pack_r(7'b0000001, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, OPC_OP);
`else
            OP_MUL:  enc_bad = 1'b1;
`endif
            default: enc_bad = 1'b1;
        endcase
    end

    assign req_accept_o  = (level_q < DEPTH_L) && !flush_i;
    assign inst_valid_o  = (level_q != '0);
    assign inst_opcode_o = mem_q[rd_ptr_q];
    assign inst_error_o  = error_q;
    assign level_o       = level_q;

    assign push = req_valid_i && req_accept_o && !enc_bad;
    assign pop  = inst_valid_o && inst_accept_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        error_d  = req_valid_i && req_accept_o && enc_bad;
        // Flush wins over a same-cycle pop; pushes are already blocked by req_accept_o.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = enc_word;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            error_q  <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            error_q  <= error_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_biriscv_inst_encoder.sv
// Directed self-checking bench for biriscv_inst_encoder (DEPTH=4).
module tb_biriscv_inst_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_accept_o;
    logic [3:0]  req_op_i;
    logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
    logic [31:0] req_imm_i;
    logic        inst_valid_o;
    logic        inst_accept_i;
    logic [31:0] inst_opcode_o;
    logic        inst_error_o;
    logic [2:0]  level_o;
    logic        flush_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    biriscv_inst_encoder #(.DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_accept_o  (req_accept_o),
        .req_op_i      (req_op_i),
        .req_rd_i      (req_rd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_imm_i     (req_imm_i),
        .inst_valid_o  (inst_valid_o),
        .inst_accept_i (inst_accept_i),
        .inst_opcode_o (inst_opcode_o),
        .inst_error_o  (inst_error_o),
        .level_o       (level_o),
        .flush_i       (flush_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        req_op_i    = op;
        req_rd_i    = rd;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        req_imm_i   = imm;
        req_valid_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        drive_req(op, rd, rs1, rs2, imm);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic pop();
        inst_accept_i = 1'b1;
        step();
        inst_accept_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
        checks++; if (inst_error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", inst_error_o); end
        checks++; if (inst_opcode_o !== 32'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 00000000", inst_opcode_o); end
        rst_i = 1'b0;
        step();
        checks++; if (req_accept_o !== 1'b1) begin errors++; $display("FAIL reset_accept: got %b expected 1", req_accept_o); end
    endtask

    task automatic test_encode();
        vec_t v [16];
        v = '{
            '{4'd0,  5'd1,  5'd0, 5'd7, 32'd5,          32'h00500093},
            '{4'd12, 5'd31, 5'd1, 5'd2, 32'd8,          32'h0020A423},
            '{4'd9,  5'd5,  5'd6, 5'd7, 32'h123,        32'h407302B3},
            '{4'd7,  5'd2,  5'd3, 5'd9, 32'd4,          32'h4041D113},
            '{4'd10, 5'd1,  5'd5, 5'd5, 32'h12345000,   32'h123450B7},
            '{4'd13, 5'd9,  5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3},
            '{4'd14, 5'd1,  5'd3, 5'd4, 32'd8,          32'h008000EF},
            '{4'd4,  5'd4,  5'd4, 5'd0, 32'hFFFFFFFF,   32'hFFF27213},
            '{4'd11, 5'd2,  5'd1, 5'd0, 32'hFFFFF800,   32'h8000A103},
            '{4'd5,  5'd1,  5'd1, 5'd0, 32'd31,         32'h01F09093},
            '{4'd8,  5'd1,  5'd2, 5'd3, 32'd0,          32'h003100B3},
            '{4'd1,  5'd1,  5'd1, 5'd0, 32'd2047,       32'h7FF0A093},
            '{4'd2,  5'd2,  5'd2, 5'd0, 32'd1,          32'h00114113},
            '{4'd3,  5'd3,  5'd3, 5'd0, 32'h10,         32'h0101E193},
            '{4'd6,  5'd1,  5'd1, 5'd0, 32'd1,          32'h0010D093},
            '{4'd14, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFE,   32'hFFFFF06F}
        };
        for (int i = 0; i < 16; i++) begin
            push(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d]: got %b expected 1", i, inst_valid_o); end
            checks++; if (inst_opcode_o !== v[i].exp) begin errors++; $display("FAIL enc_word[%0d]: got %h expected %h", i, inst_opcode_o, v[i].exp); end
            checks++; if (inst_error_o !== 1'b0) begin errors++; $display("FAIL enc_noerr[%0d]: got %b expected 0", i, inst_error_o); end
            pop();
            checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL enc_drain[%0d]: got %0d expected 0", i, level_o); end
        end
    endtask

    task automatic test_mul();
        push(4'd15, 5'd3, 5'd1, 5'd2, 32'd0);
`ifdef BIRISCV_ENCODER_MULDIV_EN
        checks++; if (inst_opcode_o !== 32'h022081B3) begin errors++; $display("FAIL mul_word: got %h expected 022081B3", inst_opcode_o); end
        checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL mul_level: got %0d expected 1", level_o); end
        pop();
`else
        checks++; if (inst_error_o !== 1'b1) begin errors++; $display("FAIL mul_error: got %b expected 1", inst_error_o); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL mul_level: got %0d expected 0", level_o); end
        step();
`endif
    endtask

    task automatic test_range_errors();
        vec_t v [6];
        v = '{
            '{4'd0,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h0},
            '{4'd13, 5'd0, 5'd1, 5'd2, 32'd3,        32'h0},
            '{4'd5,  5'd1, 5'd1, 5'd0, 32'd32,       32'h0},
            '{4'd10, 5'd1, 5'd0, 5'd0, 32'h00000001, 32'h0},
            '{4'd14, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h0},
            '{4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF, 32'h0}
        };
        for (int i = 0; i < 6; i++) begin
            drive_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            step();
            checks++; if (inst_error_o !== 1'b1) begin errors++; $display("FAIL rng_error[%0d]: got %b expected 1", i, inst_error_o); end
            checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rng_level[%0d]: got %0d expected 0", i, level_o); end
        end
        req_valid_i = 1'b0;
        step();
        checks++; if (inst_error_o !== 1'b0) begin errors++; $display("FAIL rng_pulse_end: got %b expected 0", inst_error_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rng_valid: got %b expected 0", inst_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 1; i <= 4; i++) begin
            drive_req(4'd0, 5'd1, 5'd0, 5'd0, 32'(i));
            step();
        end
        req_valid_i = 1'b0;
        checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level_o); end
        checks++; if (req_accept_o !== 1'b0) begin errors++; $display("FAIL full_accept: got %b expected 0", req_accept_o); end
        checks++; if (inst_opcode_o !== 32'h00100093) begin errors++; $display("FAIL full_head: got %h expected 00100093", inst_opcode_o); end
        // push while full plus pop: the push must not be taken
        drive_req(4'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        inst_accept_i = 1'b1;
        step();
        checks++; if (level_o !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d expected 3", level_o); end
        checks++; if (req_accept_o !== 1'b1) begin errors++; $display("FAIL pop_accept: got %b expected 1", req_accept_o); end
        checks++; if (inst_opcode_o !== 32'h00200093) begin errors++; $display("FAIL pop_head2: got %h expected 00200093", inst_opcode_o); end
        drive_req(4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        req_valid_i   = 1'b0;
        inst_accept_i = 1'b0;
        checks++; if (level_o !== 3'd3) begin errors++; $display("FAIL pushpop_level: got %0d expected 3", level_o); end
        for (int i = 3; i <= 5; i++) begin
            exp = {12'(i), 20'h00093};
            checks++; if (inst_opcode_o !== exp) begin errors++; $display("FAIL order[%0d]: got %h expected %h", i, inst_opcode_o, exp); end
            pop();
        end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", inst_valid_o); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) push(4'd0, 5'd1, 5'd0, 5'd0, 32'(i));
        checks++; if (level_o !== 3'd3) begin errors++; $display("FAIL flush_pre_level: got %0d expected 3", level_o); end
        flush_i       = 1'b1;
        inst_accept_i = 1'b1;
        drive_req(4'd0, 5'd1, 5'd0, 5'd0, 32'd6);
        #1;
        checks++; if (req_accept_o !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b expected 0", req_accept_o); end
        @(posedge clk_i);
        #1;
        flush_i       = 1'b0;
        inst_accept_i = 1'b0;
        req_valid_i   = 1'b0;
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", inst_valid_o); end
        push(4'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        checks++; if (inst_opcode_o !== 32'h00700093) begin errors++; $display("FAIL flush_after: got %h expected 00700093", inst_opcode_o); end
        pop();
    endtask

    task automatic test_reset_mid();
        push(4'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        push(4'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        rst_i         = 1'b1;
        inst_accept_i = 1'b1;
        drive_req(4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", inst_valid_o); end
        checks++; if (inst_error_o !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b expected 0", inst_error_o); end
        checks++; if (inst_opcode_o !== 32'h0) begin errors++; $display("FAIL rstmid_opcode: got %h expected 00000000", inst_opcode_o); end
        rst_i         = 1'b0;
        inst_accept_i = 1'b0;
        req_valid_i   = 1'b0;
        step();
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid: got %b expected 0", inst_valid_o); end
    endtask

    initial begin
        rst_i         = 1'b1;
        req_valid_i   = 1'b0;
        req_op_i      = '0;
        req_rd_i      = '0;
        req_rs1_i     = '0;
        req_rs2_i     = '0;
        req_imm_i     = '0;
        inst_accept_i = 1'b0;
        flush_i       = 1'b0;
        test_reset();
        test_encode();
        test_mul();
        test_range_errors();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biriscv_inst_encoder.md
BIRISCV_INST_ENCODER -- requirements
Module: biriscv_inst_encoder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, number of output FIFO entries (power of two, 2..16).
REQ-002 The module SHALL have port clk_i, input, 1, the only clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port req_valid_i, input, 1, encode request present.
REQ-005 The module SHALL have port req_accept_o, output, 1, request taken this cycle.
REQ-006 The module SHALL have port req_op_i, input, 4, operation: 0 ADDI, 1 SLTI, 2 XORI, 3 ORI, 4 ANDI, 5 SLLI, 6 SRLI, 7 SRAI, 8 ADD, 9 SUB, 10 LUI, 11 LW, 12 SW, 13 BEQ, 14 JAL, 15 MUL.
REQ-007 The module SHALL have ports req_rd_i, req_rs1_i and req_rs2_i, input, 5 each, register indices.
REQ-008 The module SHALL have port req_imm_i, input, 32, signed immediate or offset.
REQ-009 The module SHALL have port inst_valid_o, output, 1, encoded instruction available at the FIFO head.
REQ-010 The module SHALL have port inst_accept_i, input, 1, consumer takes the head entry.
REQ-011 The module SHALL have port inst_opcode_o, output, 32, RV32 instruction word at the head.
REQ-012 The module SHALL have port inst_error_o, output, 1, one-cycle pulse for a rejected request.
REQ-013 The module SHALL have port level_o, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-014 The module SHALL have port flush_i, input, 1, discard all queued entries.

Function
REQ-015 Push handshake: a request SHALL be taken when req_valid_i && req_accept_o.
- req_accept_o = (level_o < DEPTH) && !flush_i.
- Acceptance is not widened by a same-cycle pop when full; there is no bypass.
REQ-016 Pop handshake: the head entry SHALL be removed when inst_valid_o && inst_accept_i.
- inst_valid_o = (level_o != 0).
- inst_opcode_o is driven from a registered FIFO entry and is held stable while inst_valid_o && !inst_accept_i.
REQ-017 Latency: a request accepted at edge N into an empty FIFO SHALL show inst_valid_o=1 with its word from cycle N+1.
REQ-018 Simultaneous push and pop SHALL leave level_o unchanged. Read and write pointers wrap modulo DEPTH.
REQ-019 Encoding SHALL follow RV32I/M exactly. Field placement:
- rd in [11:7]; rs1 in [19:15]; rs2 in [24:20].
- Unused register fields are forced to 0.
- I-type, S-type, B-type, U-type and J-type immediates are scrambled per the ISA.
- SUB and SRAI set bit 30. MUL sets funct7=0000001.
REQ-020 Range checks SHALL apply before encoding:
- I-type, LW and SW: req_imm_i[31:11] all equal.
- Shifts: req_imm_i[31:5] == 0.
- LUI: req_imm_i[11:0] == 0; bits [31:12] are used.
- BEQ: req_imm_i[0] == 0 and req_imm_i[31:12] all equal.
- JAL: req_imm_i[0] == 0 and req_imm_i[31:20] all equal.
REQ-021 A failing request SHALL still be accepted, is not enqueued, and pulses inst_error_o in the cycle after acceptance.
REQ-022 flush_i SHALL empty the FIFO at the next edge; any pop in the same cycle is ignored.

Reset
REQ-023 While rst_i is high at a clock edge, the module SHALL clear both pointers and level_o, and drive inst_valid_o=0, inst_error_o=0 and inst_opcode_o=0.
REQ-024 Reset SHALL take priority over flush_i, push and pop in the same cycle, and SHALL discard in-flight entries.

Configuration
REQ-025 With macro BIRISCV_ENCODER_MULDIV_EN defined, op 15 SHALL encode MUL.
REQ-026 Without BIRISCV_ENCODER_MULDIV_EN, op 15 SHALL be treated as a failed range check per REQ-021, and no multiply logic is present.

Verification
REQ-027 ADDI rd=1, rs1=0, imm=5 -> the bench SHALL see 0x00500093 at the head one cycle after accept.
REQ-028 SW rs1=1, rs2=2, imm=8 -> the bench SHALL see 0x0020A423.
REQ-029 MUL rd=3, rs1=1, rs2=2 -> the bench SHALL see 0x022081B3 with the macro, and an inst_error_o pulse with no enqueue without it.
REQ-030 ADDI imm=2048, then BEQ imm=3 -> the bench SHALL see two inst_error_o pulses and level_o remaining 0.
REQ-031 DEPTH=4, push 4 requests with inst_accept_i=0 -> the bench SHALL see req_accept_o=0 and level_o=4. After one pop, req_accept_o=1 in the following cycle, and pop order matches push order.
REQ-032 level_o=3, assert flush_i together with inst_accept_i -> the bench SHALL see level_o=0 and inst_valid_o=0 next cycle. rst_i asserted mid-stream -> all outputs SHALL be at their reset values next cycle.
